// File: rtl/sequenciador_ultrassom_if.sv
// ---------------------------------------------------------------------------
// sequenciador_ultrassom_if
// Bundle between the ultrasonic sweep sequencer and the three HC-SR04
// sensor interfaces of the datapath.
//   medir1..3         : one-cycle measure request, one per sensor
//   zera_sensor       : one-cycle reset pulse to the sensor interfaces
//   pronto_medida1..3 : done pulse from each sensor interface
//   medida1..3        : 12-bit measurement, valid while pronto_medidaN=1
// master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface sequenciador_ultrassom_if;
  logic        medir1;
  logic        medir2;
  logic        medir3;
  logic        zera_sensor;
  logic        pronto_medida1;
  logic        pronto_medida2;
  logic        pronto_medida3;
  logic [11:0] medida1;
  logic [11:0] medida2;
  logic [11:0] medida3;

  modport master (
    output medir1, medir2, medir3, zera_sensor,
    input  pronto_medida1, pronto_medida2, pronto_medida3,
    input  medida1, medida2, medida3
  );

  modport slave (
    input  medir1, medir2, medir3, zera_sensor,
    output pronto_medida1, pronto_medida2, pronto_medida3,
    output medida1, medida2, medida3
  );
endinterface

// File: rtl/sequenciador_ultrassom.sv
// ---------------------------------------------------------------------------
// sequenciador_ultrassom
// Measures three HC-SR04 sensors strictly one at a time (1 -> 2 -> 3) so
// that no two sensors ping simultaneously. For each sensor: one-cycle
// medir, wait for pronto_medida or a timeout, latch the result (12'hFFF on
// timeout), then a guard interval before the next sensor.
//
// Ports:
//   clock        : system clock, rising edge
//   reset        : asynchronous, active-low reset
//   iniciar      : start one 3-sensor sweep (only honoured while idle)
//   sensores     : sensor-side bundle (medir/zera_sensor out,
//                  pronto_medida/medida in)
//   medida_out1..3 : results of the last sweep
//   timeout      : bit N-1 set if sensor N timed out in the last sweep
//   ocupado      : high whenever the sequencer is not idle
//   pronto       : one-cycle pulse at the end of a sweep
//   db_estado    : current state encoding, for debug
// ---------------------------------------------------------------------------
module sequenciador_ultrassom #(
  parameter int unsigned TIMEOUT_CICLOS = 3000000,
  parameter int unsigned GUARDA_CICLOS  = 500000,
  parameter bit          CONTINUO       = 1'b0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  sequenciador_ultrassom_if.master sensores,
  output logic [11:0]              medida_out1,
  output logic [11:0]              medida_out2,
  output logic [11:0]              medida_out3,
  output logic [2:0]               timeout,
  output logic                     ocupado,
  output logic                     pronto,
  output logic [3:0]               db_estado
);

  // A zero-length interval would never reach its terminal count; treat 0 as 1.
  localparam int unsigned TIMEOUT_EF = (TIMEOUT_CICLOS == 0) ? 1 : TIMEOUT_CICLOS;
  localparam int unsigned GUARDA_EF  = (GUARDA_CICLOS  == 0) ? 1 : GUARDA_CICLOS;
  localparam int unsigned MAX_CICLOS = (TIMEOUT_EF > GUARDA_EF) ? TIMEOUT_EF : GUARDA_EF;
  localparam int unsigned CW         = (MAX_CICLOS > 1) ? $clog2(MAX_CICLOS) : 1;

  localparam logic [CW-1:0] FIM_TIMEOUT = CW'(TIMEOUT_EF - 1);
  localparam logic [CW-1:0] FIM_GUARDA  = CW'(GUARDA_EF - 1);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PREPARA  = 4'd1,
    MEDE     = 4'd2,
    ESPERA   = 4'd3,
    ARMAZENA = 4'd4,
    GUARDA   = 4'd5,
    PROXIMO  = 4'd6,
    FIM      = 4'd7
  } estado_t;

  estado_t          estado_q,     estado_d;
  logic [1:0]       indice_q,     indice_d;
  logic [CW-1:0]    contador_q,   contador_d;
  logic [11:0]      medida_lat_q, medida_lat_d;
  logic [2:0]       timeout_q,    timeout_d;
  logic [2:0][11:0] medida_out_q, medida_out_d;

  logic [2:0]  medir;
  logic        zera;
  logic        pronto_sel;
  logic [11:0] medida_sel;

  // Only the currently selected sensor is listened to; the others' pronto
  // pulses are ignored.
  always_comb begin
    pronto_sel = 1'b0;
    medida_sel = '0;
    case (indice_q)
      2'd0: begin
        pronto_sel = sensores.pronto_medida1;
        medida_sel = sensores.medida1;
      end
      2'd1: begin
        pronto_sel = sensores.pronto_medida2;
        medida_sel = sensores.medida2;
      end
      2'd2: begin
        pronto_sel = sensores.pronto_medida3;
        medida_sel = sensores.medida3;
      end
      default: begin
        pronto_sel = 1'b0;
        medida_sel = '0;
      end
    endcase
  end

  always_comb begin
    estado_d     = estado_q;
    indice_d     = indice_q;
    contador_d   = contador_q;
    medida_lat_d = medida_lat_q;
    timeout_d    = timeout_q;
    medida_out_d = medida_out_q;
    medir        = '0;
    zera         = 1'b0;

    case (estado_q)
      INICIAL: begin
        contador_d = '0;
        if (iniciar || CONTINUO) estado_d = PREPARA;
      end

      PREPARA: begin
        indice_d   = '0;
        contador_d = '0;
        timeout_d  = '0;
        estado_d   = MEDE;
      end

      MEDE: begin
        medir[indice_q] = 1'b1;
        contador_d      = '0;
        estado_d        = ESPERA;
      end

      // pronto is tested before the terminal count so a reply on the last
      // cycle still counts as a valid measurement.
      ESPERA: begin
        contador_d = contador_q + 1'b1;
        if (pronto_sel) begin
          medida_lat_d = medida_sel;
          estado_d     = ARMAZENA;
        end else if (contador_q == FIM_TIMEOUT) begin
          timeout_d[indice_q] = 1'b1;
          estado_d            = ARMAZENA;
        end
      end

      // timeout_q[indice_q] is the flag raised in ESPERA for this sensor;
      // it doubles as the zera_sensor request for this one cycle.
      ARMAZENA: begin
        medida_out_d[indice_q] = timeout_q[indice_q] ? 12'hFFF : medida_lat_q;
        zera                   = timeout_q[indice_q];
        contador_d             = '0;
        estado_d               = GUARDA;
      end

      GUARDA: begin
        contador_d = contador_q + 1'b1;
        if (contador_q == FIM_GUARDA) estado_d = PROXIMO;
      end

      PROXIMO: begin
        contador_d = '0;
        if (indice_q == 2'd2) begin
          estado_d = FIM;
        end else begin
          indice_d = indice_q + 2'd1;
          estado_d = MEDE;
        end
      end

      FIM: begin
        estado_d = INICIAL;
      end

      default: begin
        estado_d = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= INICIAL;
      indice_q     <= '0;
      contador_q   <= '0;
      medida_lat_q <= '0;
      timeout_q    <= '0;
      medida_out_q <= '0;
    end else begin
      estado_q     <= estado_d;
      indice_q     <= indice_d;
      contador_q   <= contador_d;
      medida_lat_q <= medida_lat_d;
      timeout_q    <= timeout_d;
      medida_out_q <= medida_out_d;
    end
  end

  // Control outputs are decoded from the state register, so they all drop
  // together with an asynchronous reset.
  always_comb begin
    sensores.medir1      = medir[0];
    sensores.medir2      = medir[1];
    sensores.medir3      = medir[2];
    sensores.zera_sensor = zera;
    medida_out1          = medida_out_q[0];
    medida_out2          = medida_out_q[1];
    medida_out3          = medida_out_q[2];
    timeout              = timeout_q;
    ocupado              = (estado_q != INICIAL);
    pronto               = (estado_q == FIM);
    db_estado            = estado_q;
  end

endmodule

// File: tb/tb_sequenciador_ultrassom.sv
`timescale 1ns/1ps
module tb_sequenciador_ultrassom;
  localparam int unsigned T = 100;
  localparam int unsigned G = 10;

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic reset_c = 1'b0;
  logic iniciar = 1'b0;
  always #5 clock = ~clock;

  sequenciador_ultrassom_if sens();
  sequenciador_ultrassom_if sens_c();

  logic [11:0] mo1, mo2, mo3, mc1, mc2, mc3;
  logic [2:0]  to, to_c;
  logic        oc, pr, oc_c, pr_c;
  logic [3:0]  dbe, dbe_c;

  sequenciador_ultrassom #(.TIMEOUT_CICLOS(T), .GUARDA_CICLOS(G), .CONTINUO(1'b0)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .sensores(sens),
    .medida_out1(mo1), .medida_out2(mo2), .medida_out3(mo3),
    .timeout(to), .ocupado(oc), .pronto(pr), .db_estado(dbe)
  );

  sequenciador_ultrassom #(.TIMEOUT_CICLOS(T), .GUARDA_CICLOS(G), .CONTINUO(1'b1)) dut_c (
    .clock(clock), .reset(reset_c), .iniciar(1'b0), .sensores(sens_c),
    .medida_out1(mc1), .medida_out2(mc2), .medida_out3(mc3),
    .timeout(to_c), .ocupado(oc_c), .pronto(pr_c), .db_estado(dbe_c)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, act, exp, cyc);
  endtask

  // Sensor behaviour configuration (main DUT)
  int          d_cfg   [3];
  bit          ans_cfg [3];
  logic [11:0] val_cfg [3];
  bit          spur_en = 1'b0;

  // Reference model: event times of the current sweep
  bit          m_have = 1'b0;
  int          m_start, m_fim;
  int          m_tm [3];
  int          m_ta [3];
  bit          m_to [3];
  logic [11:0] m_val[3];
  logic [11:0] e_med[3];
  logic [2:0]  e_to = '0;

  // Monitors
  int mon_zera_n = 0, mon_zera_cyc = -1, mon_medir2_cyc = -1;
  int mon_pr_n = 0,   mon_pr_cyc = -1;
  int c_pr[$];
  int c_low[$];
  int low_cnt = 0;

  // Response scheduling
  int r_at [3]  = '{-1, -1, -1};
  int rc_at [3] = '{-1, -1, -1};

  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) r_at[k] = -1;
    end else begin
      if (sens.medir1 && ans_cfg[0]) r_at[0] = cyc + d_cfg[0];
      if (sens.medir2 && ans_cfg[1]) r_at[1] = cyc + d_cfg[1];
      if (sens.medir3 && ans_cfg[2]) r_at[2] = cyc + d_cfg[2];
    end
    if (sens_c.medir1) rc_at[0] = cyc + 20;
    if (sens_c.medir2) rc_at[1] = cyc + 20;
    if (sens_c.medir3) rc_at[2] = cyc + 20;
  end

  // Sensor drivers: medida carries junk except in the pronto cycle
  initial begin
    logic [2:0] p, pc;
    sens.pronto_medida1 = 0; sens.pronto_medida2 = 0; sens.pronto_medida3 = 0;
    sens.medida1 = '0; sens.medida2 = '0; sens.medida3 = '0;
    sens_c.pronto_medida1 = 0; sens_c.pronto_medida2 = 0; sens_c.pronto_medida3 = 0;
    sens_c.medida1 = '0; sens_c.medida2 = '0; sens_c.medida3 = '0;
    forever begin
      @(posedge clock);
      #1;
      p  = '0;
      pc = '0;
      for (int k = 0; k < 3; k++) begin
        if (r_at[k] == cyc)  p[k]  = 1'b1;
        if (rc_at[k] == cyc) pc[k] = 1'b1;
      end
      if (spur_en && m_have && cyc == m_tm[0] + 5) p[2] = 1'b1;
      sens.pronto_medida1 = p[0];
      sens.pronto_medida2 = p[1];
      sens.pronto_medida3 = p[2];
      sens.medida1 = (p[0] && r_at[0] == cyc) ? val_cfg[0] : 12'($urandom);
      sens.medida2 = p[1] ? val_cfg[1] : 12'($urandom);
      sens.medida3 = (p[2] && r_at[2] == cyc) ? val_cfg[2] : 12'($urandom);
      sens_c.pronto_medida1 = pc[0];
      sens_c.pronto_medida2 = pc[1];
      sens_c.pronto_medida3 = pc[2];
      sens_c.medida1 = pc[0] ? 12'h111 : 12'($urandom);
      sens_c.medida2 = pc[1] ? 12'h222 : 12'($urandom);
      sens_c.medida3 = pc[2] ? 12'h333 : 12'($urandom);
    end
  end

  // Per-cycle comparison against the event-time model
  always @(negedge clock) begin
    logic [2:0] e_medir;
    logic       e_zera, e_pr, e_oc;
    logic [3:0] e_db;
    int         t, w;

    if (!reset) begin
      m_have = 1'b0;
      e_to   = '0;
      for (int k = 0; k < 3; k++) e_med[k] = '0;
    end else if (m_have) begin
      if (cyc == m_start + 1) e_to = '0;
      for (int k = 0; k < 3; k++) begin
        if (cyc == m_ta[k] && m_to[k]) e_to[k] = 1'b1;
        if (cyc == m_ta[k] + 1) e_med[k] = m_to[k] ? 12'hFFF : m_val[k];
      end
    end

    e_medir = '0; e_zera = 1'b0; e_pr = 1'b0; e_oc = 1'b0; e_db = 4'd0;
    if (m_have && cyc >= m_start && cyc <= m_fim) begin
      e_oc = 1'b1;
      if (cyc == m_start) e_db = 4'd1;
      if (cyc == m_fim) begin e_db = 4'd7; e_pr = 1'b1; end
      for (int k = 0; k < 3; k++) begin
        if (cyc == m_tm[k]) begin e_db = 4'd2; e_medir[k] = 1'b1; end
        else if (cyc > m_tm[k] && cyc < m_ta[k]) e_db = 4'd3;
        else if (cyc == m_ta[k]) begin e_db = 4'd4; e_zera = m_to[k]; end
        else if (cyc > m_ta[k] && cyc <= m_ta[k] + int'(G)) e_db = 4'd5;
        else if (cyc == m_ta[k] + int'(G) + 1) e_db = 4'd6;
      end
    end

    chk("medir",     {29'd0, sens.medir3, sens.medir2, sens.medir1}, {29'd0, e_medir});
    chk("zera",      32'(sens.zera_sensor), 32'(e_zera));
    chk("pronto",    32'(pr),  32'(e_pr));
    chk("ocupado",   32'(oc),  32'(e_oc));
    chk("db_estado", 32'(dbe), 32'(e_db));
    chk("medida_out1", 32'(mo1), 32'(e_med[0]));
    chk("medida_out2", 32'(mo2), 32'(e_med[1]));
    chk("medida_out3", 32'(mo3), 32'(e_med[2]));
    chk("timeout",   32'(to),  32'(e_to));

    if (sens.zera_sensor) begin mon_zera_n++; mon_zera_cyc = cyc; end
    if (sens.medir2) mon_medir2_cyc = cyc;
    if (pr) begin mon_pr_n++; mon_pr_cyc = cyc; end

    if (reset && iniciar && !(m_have && cyc <= m_fim)) begin
      m_have  = 1'b1;
      m_start = cyc + 1;
      t = m_start + 1;
      for (int k = 0; k < 3; k++) begin
        m_tm[k]  = t;
        m_to[k]  = !(ans_cfg[k] && d_cfg[k] <= int'(T));
        w        = m_to[k] ? int'(T) : d_cfg[k];
        m_ta[k]  = t + w + 1;
        m_val[k] = val_cfg[k];
        t        = m_ta[k] + int'(G) + 2;
      end
      m_fim = t;
    end

    if (reset_c) begin
      if (pr_c) begin
        c_pr.push_back(cyc);
        c_low.push_back(low_cnt);
        low_cnt = 0;
      end else if (!oc_c) begin
        low_cnt++;
      end
    end
  end

  task automatic run_sweep(input int reinicia_em, output int lat);
    int c0, pr0;
    bit seen;
    pr0 = mon_pr_n;
    @(posedge clock); #1;
    iniciar = 1'b1;
    c0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clock); #1;
      iniciar = (reinicia_em > 0 && cyc == c0 + reinicia_em);
      if (mon_pr_n != pr0) seen = 1'b1;
    end
    iniciar = 1'b0;
    if (!seen) chk("sweep_done", 32'd0, 32'd1);
    lat = mon_pr_cyc - c0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int lat, z0, p0;
    bit hit;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, z0, p0;
    bit hit;
    d_cfg   = '{20, 20, 20};
    ans_cfg = '{1'b1, 1'b1, 1'b1};
    val_cfg = '{12'h0A5, 12'h123, 12'h7FF};

    repeat (3) @(posedge clock);
    #1;
    chk("rst_medida_out1", 32'(mo1), 32'h0);
    chk("rst_timeout", 32'(to), 32'h0);
    chk("rst_db_estado", 32'(dbe), 32'h0);
    chk("rst_ocupado", 32'(oc), 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // Normal sweep
    z0 = mon_zera_n; p0 = mon_pr_n;
    run_sweep(0, lat);
    chk("lat_normal", lat, 101);
    chk("norm_mo1", 32'(mo1), 32'h0A5);
    chk("norm_mo2", 32'(mo2), 32'h123);
    chk("norm_mo3", 32'(mo3), 32'h7FF);
    chk("norm_timeout", 32'(to), 32'h0);
    chk("norm_pronto_count", mon_pr_n - p0, 1);
    chk("norm_zera_count", mon_zera_n - z0, 0);

    // Sensor 2 never answers
    ans_cfg[1] = 1'b0;
    z0 = mon_zera_n;
    run_sweep(0, lat);
    chk("lat_timeout", lat, 181);
    chk("to_zera_count", mon_zera_n - z0, 1);
    chk("to_zera_delay", mon_zera_cyc - mon_medir2_cyc, 101);
    chk("to_mo1", 32'(mo1), 32'h0A5);
    chk("to_mo2", 32'(mo2), 32'hFFF);
    chk("to_mo3", 32'(mo3), 32'h7FF);
    chk("to_timeout", 32'(to), 32'h2);
    ans_cfg[1] = 1'b1;

    // Sensor 1 answers on the terminal-count cycle
    d_cfg[0] = 100; val_cfg[0] = 12'h3C3;
    z0 = mon_zera_n;
    run_sweep(0, lat);
    chk("lat_race", lat, 181);
    chk("race_timeout", 32'(to), 32'h0);
    chk("race_mo1", 32'(mo1), 32'h3C3);
    chk("race_zera_count", mon_zera_n - z0, 0);
    d_cfg[0] = 20; val_cfg[0] = 12'h0A5;

    // Spurious pronto_medida3 during sensor 1 and a re-pulsed iniciar
    spur_en = 1'b1;
    p0 = mon_pr_n;
    run_sweep(50, lat);
    spur_en = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("spur_lat", lat, 101);
    chk("spur_pronto_count", mon_pr_n - p0, 1);
    chk("spur_mo3", 32'(mo3), 32'h7FF);

    // Reset during GUARDA of sensor 2
    p0 = mon_pr_n;
    @(posedge clock); #1;
    iniciar = 1'b1;
    @(posedge clock); #1;
    iniciar = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(posedge clock); #1;
      if (cyc == m_ta[1] + 3) hit = 1'b1;
    end
    if (!hit) chk("reach_guarda2", 32'd0, 32'd1);
    chk("pre_rst_db_estado", 32'(dbe), 32'h5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_db_estado", 32'(dbe), 32'h0);
    chk("async_ocupado", 32'(oc), 32'h0);
    chk("async_mo1", 32'(mo1), 32'h0);
    chk("async_mo2", 32'(mo2), 32'h0);
    chk("async_timeout", 32'(to), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (130) @(posedge clock);
    #1;
    chk("rst_no_pronto", mon_pr_n - p0, 0);
    run_sweep(0, lat);
    chk("post_rst_lat", lat, 101);
    chk("post_rst_mo1", 32'(mo1), 32'h0A5);
    chk("post_rst_mo2", 32'(mo2), 32'h123);
    chk("post_rst_mo3", 32'(mo3), 32'h7FF);

    // Continuous mode on the second instance
    reset_c = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(posedge clock); #1;
      if (c_pr.size() >= 3) hit = 1'b1;
    end
    if (!hit) begin
      chk("cont_sweeps", c_pr.size(), 3);
    end else begin
      chk("cont_gap1", c_pr[1] - c_pr[0], 102);
      chk("cont_gap2", c_pr[2] - c_pr[1], 102);
      chk("cont_idle1", c_low[1], 1);
      chk("cont_idle2", c_low[2], 1);
      chk("cont_mc1", 32'(mc1), 32'h111);
      chk("cont_mc3", 32'(mc3), 32'h333);
      chk("cont_timeout", 32'(to_c), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
